// File: rtl/arm7tdmi_lsu.sv
// ARM7TDMI-style load/store unit: a single outstanding data access with byte-lane
// steering, load extension/rotation and a bounded wait for mem_ready.
module arm7tdmi_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [3:0]  mem_be,
    input  logic        mem_ready
);

    // state  | meaning
    // IDLE   | ready for a request
    // ACCESS | strobes driven, waiting for mem_ready or timeout
    // RESP   | one-cycle response pulse
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [1:0]    off_q, off_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   be_for = 4'b0001 << off;
            2'b01:   be_for = off[1] ? 4'b1100 : 4'b0011;
            default: be_for = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_for(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b00:   wdata_for = {4{w[7:0]}};
            2'b01:   wdata_for = {2{w[15:0]}};
            default: wdata_for = w;
        endcase
    endfunction

    // Rotating by the byte offset puts the addressed byte lane at bit 0, which
    // doubles as the ARM7 unaligned word-load result.
    function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic sgn,
                                             input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] rot;
        logic [15:0] h;
        case (off)
            2'd0:    rot = rd;
            2'd1:    rot = {rd[7:0],  rd[31:8]};
            2'd2:    rot = {rd[15:0], rd[31:16]};
            default: rot = {rd[23:0], rd[31:24]};
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   load_fmt = {{24{sgn & rot[7]}}, rot[7:0]};
            2'b01:   load_fmt = {{16{sgn & h[15]}}, h};
            default: load_fmt = rot;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d     = S_ACCESS;
                    cnt_d       = CNT_LOAD;
                    write_d     = req_write;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    off_d       = req_addr[1:0];
                    mem_re_d    = !req_write;
                    mem_we_d    = req_write;
                    mem_be_d    = be_for(req_size, req_addr[1:0]);
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_wdata_d = wdata_for(req_size, req_wdata);
                end
            end
            S_ACCESS: begin
                if (mem_ready || cnt_q == '0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !mem_ready;
                    rsp_rdata_d = (mem_ready && !write_q)
                                  ? load_fmt(size_q, signed_q, off_q, mem_rdata) : 32'h0;
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'b0000;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            off_q       <= 2'b00;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_arm7tdmi_lsu.sv
// Scoreboard bench for arm7tdmi_lsu: stimulus pushes expected memory accesses and
// responses; a negedge monitor compares whatever the DUT presents.
module tb_arm7tdmi_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_ready;
    logic [3:0]  mem_be;

    logic ready_en;
    int   stall_cycles;
    int   wait_ctr;
    int   cyc;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;
    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_t;

    rsp_t exp_q[$];
    mem_t mexp_q[$];
    int   acc_q[$];

    arm7tdmi_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_be(mem_be), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: ready after stall_cycles strobe cycles of the current access.
    always @(posedge clk) begin
        if (mem_re || mem_we) wait_ctr <= wait_ctr + 1;
        else                  wait_ctr <= 0;
    end
    assign mem_ready = ready_en && (wait_ctr >= stall_cycles);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        rsp_t r;
        mem_t m;
        int   a;
        if (!rst) begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (mem_re || mem_we) begin
                if (mexp_q.size() == 0) begin
                    chk("unexpected_mem_access", 32'(mem_re || mem_we), 32'h0);
                end else begin
                    m = mexp_q[0];
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    chk("mem_re", 32'(mem_re), 32'(!m.we));
                    chk("mem_be", 32'(mem_be), 32'(m.be));
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_wdata", mem_wdata, m.wdata);
                end
            end else begin
                chk("idle_mem_be", 32'(mem_be), 32'h0);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
                end else begin
                    r = exp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("rsp_latency", 32'(cyc - a), 32'(r.lat));
                    if (mexp_q.size() != 0) void'(mexp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with req_valid still high.
    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mrd, input logic [3:0] e_be,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                        output int acc_cyc);
        logic hs;
        rsp_t r;
        mem_t m;
        r.rdata = e_rdata; r.err = e_err; r.lat = e_lat;
        m.we = we; m.be = e_be; m.addr = e_addr; m.wdata = e_wdata;
        exp_q.push_back(r);
        mexp_q.push_back(m);
        req_write  = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_rdata  = mrd;
        req_valid  = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            hs = req_ready;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("accept_timeout", 32'(hs), 32'h1);
        acc_cyc = cyc;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) chk("response_timeout", 32'(exp_q.size()), 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2;
        cyc = 0; wait_ctr = 0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0;
        ready_en = 1'b1; stall_cycles = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_strobes", 32'({mem_re, mem_we, mem_be}), 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;

        // Loads and stores, zero wait states
        send(0, 2'b10, 0, 32'h0000_1000, 32'h0, 32'h1234_5678, 4'b1111, 32'h1000, 32'h0, 32'h1234_5678, 0, 2, t0); drain();
        send(0, 2'b00, 0, 32'h0000_1006, 32'h0, 32'hABCD_EF00, 4'b0100, 32'h1004, 32'h0, 32'h0000_00CD, 0, 2, t0); drain();
        send(0, 2'b00, 1, 32'h0000_1006, 32'h0, 32'hABCD_EF00, 4'b0100, 32'h1004, 32'h0, 32'hFFFF_FFCD, 0, 2, t0); drain();
        send(0, 2'b10, 0, 32'h0000_1001, 32'h0, 32'h1234_5678, 4'b1111, 32'h1000, 32'h0, 32'h7812_3456, 0, 2, t0); drain();
        send(1, 2'b01, 0, 32'h0000_1002, 32'hDEAD_0005, 32'h0, 4'b1100, 32'h1000, 32'h0005_0005, 32'h0, 0, 2, t0); drain();
        send(1, 2'b00, 0, 32'h0000_2003, 32'h1122_3344, 32'h0, 4'b1000, 32'h2000, 32'h4444_4444, 32'h0, 0, 2, t0); drain();
        send(1, 2'b10, 0, 32'h0000_3002, 32'hCAFE_BABE, 32'h0, 4'b1111, 32'h3000, 32'hCAFE_BABE, 32'h0, 0, 2, t0); drain();
        send(0, 2'b01, 1, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 4'b1100, 32'h4000, 32'h0, 32'hFFFF_8001, 0, 2, t0); drain();
        send(0, 2'b01, 0, 32'h0000_4001, 32'h0, 32'h8001_7FFF, 4'b0011, 32'h4000, 32'h0, 32'h0000_7FFF, 0, 2, t0); drain();
        send(0, 2'b11, 0, 32'h0000_5003, 32'h0, 32'h1234_5678, 4'b1111, 32'h5000, 32'h0, 32'h3456_7812, 0, 2, t0); drain();
        send(0, 2'b10, 1, 32'h0000_5000, 32'h0, 32'h8000_0000, 4'b1111, 32'h5000, 32'h0, 32'h8000_0000, 0, 2, t0); drain();

        // Three stall cycles: ready arrives on the terminal-count cycle and must win
        stall_cycles = 3;
        send(0, 2'b10, 0, 32'h0000_6000, 32'h0, 32'hA5A5_0F0F, 4'b1111, 32'h6000, 32'h0, 32'hA5A5_0F0F, 0, 5, t0); drain();
        send(1, 2'b01, 0, 32'h0000_6000, 32'h0000_BEEF, 32'h0, 4'b0011, 32'h6000, 32'hBEEF_BEEF, 32'h0, 0, 5, t0); drain();

        // Timeouts
        ready_en = 1'b0;
        send(0, 2'b10, 0, 32'h0000_7000, 32'h0, 32'hFFFF_FFFF, 4'b1111, 32'h7000, 32'h0, 32'h0, 1, 5, t0); drain();
        send(1, 2'b00, 0, 32'h0000_7001, 32'h0000_00A5, 32'h0, 4'b0010, 32'h7000, 32'hA5A5_A5A5, 32'h0, 1, 5, t0); drain();

        // Reset during the second ACCESS cycle of a stalled load
        ready_en = 1'b1;
        stall_cycles = 20;
        send(0, 2'b10, 0, 32'h0000_8000, 32'h0, 32'h5555_AAAA, 4'b1111, 32'h8000, 32'h0, 32'h5555_AAAA, 0, 2, t0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete(); mexp_q.delete(); acc_q.delete();
        @(negedge clk);
        chk("abort_strobes", 32'({mem_re, mem_we, mem_be}), 32'h0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        stall_cycles = 0;
        send(0, 2'b00, 1, 32'h0000_9001, 32'h0, 32'h0000_8000, 4'b0010, 32'h9000, 32'h0, 32'hFFFF_FF80, 0, 2, t0); drain();

        // req_valid held high: one acceptance every 3 cycles, responses in order
        send(0, 2'b10, 0, 32'h0000_A000, 32'h0, 32'h1122_3344, 4'b1111, 32'hA000, 32'h0, 32'h1122_3344, 0, 2, t0);
        send(0, 2'b10, 0, 32'h0000_A001, 32'h0, 32'h1122_3344, 4'b1111, 32'hA000, 32'h0, 32'h4411_2233, 0, 2, t1);
        send(0, 2'b10, 0, 32'h0000_A002, 32'h0, 32'h1122_3344, 4'b1111, 32'hA000, 32'h0, 32'h3344_1122, 0, 2, t2);
        drain();
        chk("b2b_spacing_1", 32'(t1 - t0), 32'd3);
        chk("b2b_spacing_2", 32'(t2 - t1), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
